// File: rtl/cpu_run_monitor.sv
// Run controller and end-of-test monitor for the cpu core: sequences core reset, counts cycles/retires,
// ends the run on a tohost store or timeout. Optional retire watchdog: define RUN_MON_WDOG_EN.
module cpu_run_monitor #(
   parameter int                 XLEN         = 32,
   parameter int                 CNT_W        = 32,
   parameter int                 RST_CYCLES   = 1,
   parameter int                 MAX_CYCLES   = 100,
   parameter logic [XLEN-1:0]    TOHOST_ADDR  = 32'h0000_1000,
   parameter int                 STALL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             retire,
   input  logic             mem_we,
   input  logic [XLEN-1:0]  mem_addr,
   input  logic [XLEN-1:0]  mem_wdata,
   output logic             core_reset,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic             stall,
   output logic [XLEN-1:0]  fail_code,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret_count
);

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   localparam int RST_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

   state_t           state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             core_reset_q, core_reset_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;
   logic             stall_q, stall_d;
   logic [XLEN-1:0]  fail_q, fail_d;
   logic             tohost_hit;
   logic             timeout_hit;
   logic             wdog_hit;

   assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
   assign timeout_hit = (MAX_CYCLES != 0) && (cycle_q == CNT_W'(MAX_CYCLES - 1));

`ifdef RUN_MON_WDOG_EN
   localparam int ST_W = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES + 1);
   logic [ST_W-1:0] stall_cnt_q, stall_cnt_d;

   // Counter holds zero outside RUN, so it is already clear on entry to RUN.
   always_comb begin
      stall_cnt_d = '0;
      if (state_q == S_RUN && !retire)
         stall_cnt_d = stall_cnt_q + ST_W'(1);
   end

   assign wdog_hit = (state_q == S_RUN) && !retire && (stall_cnt_q == ST_W'(STALL_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end
`else
   logic unused_stall_cfg;
   assign unused_stall_cfg = (STALL_CYCLES != 0);
   assign wdog_hit         = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cycle_d   = cycle_q;
      instret_d = instret_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      stall_d   = stall_q;
      fail_d    = fail_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_RESET;
               rst_cnt_d = RST_W'(RST_CYCLES);
               cycle_d   = '0;
               instret_d = '0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               stall_d   = 1'b0;
               fail_d    = '0;
            end
         end
         S_RESET: begin
            // <= 1 also covers a misconfigured RST_CYCLES of 0
            if (rst_cnt_q <= RST_W'(1)) state_d = S_RUN;
            else                        rst_cnt_d = rst_cnt_q - RST_W'(1);
         end
         S_RUN: begin
            cycle_d = cycle_q + CNT_W'(1);
            if (retire) instret_d = instret_q + CNT_W'(1);
            if (tohost_hit) begin
               state_d = S_DONE;
               pass_d  = (mem_wdata == XLEN'(1));
               fail_d  = mem_wdata >> 1;
            end else if (timeout_hit) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else if (wdog_hit) begin
               state_d = S_DONE;
               stall_d = 1'b1;
               pass_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      core_reset_d = (state_d != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rst_cnt_q    <= '0;
         cycle_q      <= '0;
         instret_q    <= '0;
         core_reset_q <= 1'b1;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         stall_q      <= 1'b0;
         fail_q       <= '0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         cycle_q      <= cycle_d;
         instret_q    <= instret_d;
         core_reset_q <= core_reset_d;
         pass_q       <= pass_d;
         timeout_q    <= timeout_d;
         stall_q      <= stall_d;
         fail_q       <= fail_d;
      end
   end

   assign core_reset    = core_reset_q;
   assign busy          = (state_q == S_RESET) || (state_q == S_RUN);
   assign done          = (state_q == S_DONE);
   assign pass          = pass_q;
   assign timeout       = timeout_q;
   assign stall         = stall_q;
   assign fail_code     = fail_q;
   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor with RST_CYCLES=3, MAX_CYCLES=100; expectations are hand-computed.
module tb_cpu_run_monitor;

   logic        clk = 1'b0;
   logic        reset, start, retire, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        core_reset, busy, done, pass, timeout, stall;
   logic [31:0] fail_code, cycle_count, instret_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cpu_run_monitor #(
      .XLEN(32), .CNT_W(32), .RST_CYCLES(3), .MAX_CYCLES(100),
      .TOHOST_ADDR(32'h0000_1000), .STALL_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .retire(retire),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_reset(core_reset), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .stall(stall), .fail_code(fail_code),
      .cycle_count(cycle_count), .instret_count(instret_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      retire = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
   endtask

   // start pulse, then three RESET cycles; returns in RUN cycle 1
   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!done && n < limit) begin
         tick();
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_core_reset"}, core_reset, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_stall"}, stall, 0);
      chk({tag, "_fail_code"}, fail_code, 0);
      chk({tag, "_cycles"}, cycle_count, 0);
      chk({tag, "_instret"}, instret_count, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      idle_bus();
      repeat (3) tick();
      chk_reset_state("rst");
      reset = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // Reset sequencing: start at cycle 0, core_reset 1..3, RUN from 4
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("c1_busy", busy, 1);
      chk("c1_core_reset", core_reset, 1);
      tick();
      tick();
      chk("c3_core_reset", core_reset, 1);
      tick();
      chk("c4_core_reset", core_reset, 0);
      chk("c4_busy", busy, 1);

      // 10 retires, then tohost=1 with retire on RUN cycle 20
      for (int i = 1; i <= 19; i++) begin
         retire = (i <= 10);
         tick();
      end
      retire = 1'b1; mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'd1;
      tick();
      idle_bus();
      chk("pass_done", done, 1);
      chk("pass_pass", pass, 1);
      chk("pass_cycles", cycle_count, 20);
      chk("pass_instret", instret_count, 11);
      chk("pass_core_reset", core_reset, 1);
      chk("pass_busy", busy, 0);
      chk("pass_timeout", timeout, 0);
      chk("pass_fail_code", fail_code, 0);
      tick();
      chk("hold_cycles", cycle_count, 20);
      chk("hold_pass", pass, 1);

      // Restart from DONE, ignored starts, ignored store to 0x1004, then tohost=7
      start = 1'b1;
      tick();
      chk("restart_busy", busy, 1);
      chk("restart_done", done, 0);
      chk("restart_pass", pass, 0);
      chk("restart_cycles", cycle_count, 0);
      tick();                        // start still high in RESET: ignored
      start = 1'b0;
      tick();
      tick();
      chk("restart_run_core_reset", core_reset, 0);
      start = 1'b1; mem_we = 1'b1; mem_addr = 32'h1004; mem_wdata = 32'd1;
      tick();
      start = 1'b0;
      chk("other_addr_done", done, 0);
      chk("other_addr_busy", busy, 1);
      chk("run_start_cycles", cycle_count, 1);
      mem_addr = 32'h1000; mem_wdata = 32'h7;
      tick();
      idle_bus();
      chk("fail_done", done, 1);
      chk("fail_pass", pass, 0);
      chk("fail_code", fail_code, 3);
      chk("fail_cycles", cycle_count, 2);
      chk("fail_timeout", timeout, 0);

      // Timeout with retire every cycle (keeps any watchdog quiet)
      start_run();
      retire = 1'b1;
      wait_done(200);
      idle_bus();
      chk("to_timeout", timeout, 1);
      chk("to_pass", pass, 0);
      chk("to_cycles", cycle_count, 100);
      chk("to_instret", instret_count, 100);
      chk("to_stall", stall, 0);

      // tohost store coinciding with the timeout cycle wins
      start_run();
      retire = 1'b1;
      repeat (99) tick();
      chk("pre_to_busy", busy, 1);
      mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'd1;
      tick();
      idle_bus();
      chk("race_done", done, 1);
      chk("race_pass", pass, 1);
      chk("race_timeout", timeout, 0);
      chk("race_cycles", cycle_count, 100);

      // Reset at RUN cycle 5 beats a simultaneous start
      start_run();
      repeat (4) tick();
      chk("pre_reset_cycles", cycle_count, 4);
      reset = 1'b1; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      chk_reset_state("midrun");
      tick();
      chk("after_reset_busy", busy, 0);

      // One retire then silence: watchdog trips after 16 idle cycles, else timeout
      start_run();
      retire = 1'b1;
      tick();
      retire = 1'b0;
      wait_done(200);
`ifdef RUN_MON_WDOG_EN
      chk("wd_stall", stall, 1);
      chk("wd_timeout", timeout, 0);
      chk("wd_cycles", cycle_count, 17);
`else
      chk("wd_stall", stall, 0);
      chk("wd_timeout", timeout, 1);
      chk("wd_cycles", cycle_count, 100);
`endif
      chk("wd_pass", pass, 0);
      chk("wd_instret", instret_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
